// File: rtl/mdu_iter.sv
// Iterative unsigned multiply (MUL/MULHU) and restoring divide (DIVU/REMU) unit.
// Latency: busy for WIDTH cycles after the accepting edge, then a one-cycle done pulse with y valid.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted with no bubble.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;    // MUL: {product_hi, multiplier/product_lo}; DIV: {rem, quo}
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_y;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0]   w_res;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = start;
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy   = 1'b1;
        w_last = (r_cnt == LAST);
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        w_accept = start;
        w_state_nxt = start ? S_RUN : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide, plus result select
  always_comb begin
    // Multiply: add b into the high half when the current multiplier LSB is set, then shift right
    // with the carry, so after WIDTH steps r_acc holds the full 2*WIDTH product.
    w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    // Divide: shift {rem, quo} left by one and trial-subtract b in WIDTH+1 bits.
    w_rem_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, r_b};
    if (!r_op[1])
      w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
    else if (!w_diff[WIDTH])
      w_acc_nxt = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    else
      w_acc_nxt = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    // op[0] picks the high half: MULHU -> product high, REMU -> remainder.
    w_res = r_op[0] ? w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[WIDTH-1:0];
  end

  // Operand capture, iteration datapath and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op  <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_y   <= '0;
    end else if (w_accept) begin
      r_op  <= op;
      r_b   <= b;
      r_acc <= {{WIDTH{1'b0}}, a};
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_y <= w_res;
    end
  end

  assign y = r_y;

endmodule
